frame_stream_out: RTL and testbench

- Downstream consumer of the 4x4 frame register bank (sixteen 32-bit frame words, indices 0..15, row-major: index = row*4 + col).
- On a start request, snapshots all 16 words and streams them one word per transfer over a valid/ready interface, with start-of-frame/end-of-frame flags, toward the display/transmit logic.
- Inserts a programmable blanking gap between frames and queues one start request that arrives while busy.

---
 rtl/frame_stream_out_pkg.sv | 19 +
 rtl/frame_order_map.sv | 23 ++
 rtl/frame_stream_out.sv | 162 ++++++++++++++++
 tb/tb_frame_stream_out.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_out_pkg.sv
// Shared types and constants for the frame streaming path.
// The frame-word width matches the 4x4 frame register bank that feeds this block.
package frame_stream_out_pkg;

    localparam int FRAME_DATA_W = 32;
    localparam int FRAME_DIM    = 4;
    localparam int FRAME_WORDS  = FRAME_DIM * FRAME_DIM;
    localparam int IDX_W        = $clog2(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_GAP
    } state_t;

    typedef logic [IDX_W-1:0] word_idx_t;

endpackage

// File: rtl/frame_order_map.sv
// Maps a stream position to a frame-word index: identity for row-major,
// row/column swap for column-major.
module frame_order_map
    import frame_stream_out_pkg::*;
#(
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] word_idx
);

    localparam int HALF = $clog2(FRAME_DIM);

    generate
        if (COL_MAJOR) begin : g_col
            // idx = col_pos*DIM + row_pos, so the word index is row_pos*DIM + col_pos.
            assign word_idx = {idx[HALF-1:0], idx[IDX_W-1:HALF]};
        end else begin : g_row
            assign word_idx = idx;
        end
    endgenerate

endmodule

// File: rtl/frame_stream_out.sv
// Snapshots a 4x4 frame on request and streams it word by word over valid/ready,
// with SOF/EOF flags, a blanking gap between frames and a one-deep start queue.
module frame_stream_out
    import frame_stream_out_pkg::*;
#(
    parameter int DATA_W     = FRAME_DATA_W,
    parameter bit COL_MAJOR  = 1'b0,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] frame_0_in,
    input  logic [DATA_W-1:0] frame_1_in,
    input  logic [DATA_W-1:0] frame_2_in,
    input  logic [DATA_W-1:0] frame_3_in,
    input  logic [DATA_W-1:0] frame_4_in,
    input  logic [DATA_W-1:0] frame_5_in,
    input  logic [DATA_W-1:0] frame_6_in,
    input  logic [DATA_W-1:0] frame_7_in,
    input  logic [DATA_W-1:0] frame_8_in,
    input  logic [DATA_W-1:0] frame_9_in,
    input  logic [DATA_W-1:0] frame_10_in,
    input  logic [DATA_W-1:0] frame_11_in,
    input  logic [DATA_W-1:0] frame_12_in,
    input  logic [DATA_W-1:0] frame_13_in,
    input  logic [DATA_W-1:0] frame_14_in,
    input  logic [DATA_W-1:0] frame_15_in,
    input  logic              start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam word_idx_t LAST_IDX = word_idx_t'(FRAME_WORDS - 1);

    logic [DATA_W-1:0] frame_in [FRAME_WORDS];
    logic [DATA_W-1:0] snapshot [FRAME_WORDS];

    state_t            state, state_next;
    word_idx_t         idx, idx_next, map_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic              pending;
    logic              xfer, last_xfer;
    logic              valid_d, sof_d, eof_d;
    logic [DATA_W-1:0] data_d;

    assign frame_in[0]  = frame_0_in;
    assign frame_in[1]  = frame_1_in;
    assign frame_in[2]  = frame_2_in;
    assign frame_in[3]  = frame_3_in;
    assign frame_in[4]  = frame_4_in;
    assign frame_in[5]  = frame_5_in;
    assign frame_in[6]  = frame_6_in;
    assign frame_in[7]  = frame_7_in;
    assign frame_in[8]  = frame_8_in;
    assign frame_in[9]  = frame_9_in;
    assign frame_in[10] = frame_10_in;
    assign frame_in[11] = frame_11_in;
    assign frame_in[12] = frame_12_in;
    assign frame_in[13] = frame_13_in;
    assign frame_in[14] = frame_14_in;
    assign frame_in[15] = frame_15_in;

    // out_valid is only ever set while streaming, so it alone qualifies a transfer.
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (idx == LAST_IDX);

    frame_order_map #(
        .COL_MAJOR (COL_MAJOR)
    ) u_map (
        .idx      (idx_next),
        .word_idx (map_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start || pending) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_STREAM;
            ST_STREAM: if (last_xfer) state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:    if (gap_cnt <= GAP_W'(1)) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_next = idx;
        if (state == ST_LOAD)        idx_next = '0;
        else if (xfer && !last_xfer) idx_next = idx + word_idx_t'(1);
    end

    // Next values of the registered stream outputs; they only move on LOAD or a transfer.
    always_comb begin
        // NOTE: every output starts from its held value, so no branch can infer a latch.
        valid_d = out_valid;
        sof_d   = out_sof;
        eof_d   = out_eof;
        data_d  = out_data;
        if (state == ST_LOAD) begin
            valid_d = 1'b1;
            sof_d   = 1'b1;
            eof_d   = 1'b0;
            data_d  = frame_in[map_idx];
        end else if (last_xfer) begin
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
            data_d  = '0;
        end else if (xfer) begin
            sof_d   = 1'b0;
            eof_d   = (idx_next == LAST_IDX);
            data_d  = snapshot[map_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            pending     <= 1'b0;
        end else begin
            out_data  <= data_d;
            out_valid <= valid_d;
            out_sof   <= sof_d;
            out_eof   <= eof_d;
            busy      <= (state_next != ST_IDLE);
            idx       <= idx_next;
            if (last_xfer) frames_sent <= frames_sent + CNT_W'(1);
            if (last_xfer)             gap_cnt <= GAP_LOAD;
            else if (state == ST_GAP)  gap_cnt <= gap_cnt - GAP_W'(1);
            // Leaving IDLE consumes the queued request; a start in that same cycle re-queues.
            if (state == ST_IDLE) pending <= pending && start;
            else                  pending <= pending || start;
        end
    end

    // NOTE: the snapshot is plain storage, always written before being read, so it has no reset.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) snapshot <= frame_in;
    end

endmodule

// File: tb/tb_frame_stream_out.sv
// Bench for frame_stream_out: three instances (row-major, column-major, 2-bit counter)
// share stimulus and are compared every cycle against a transaction-level model.
module tb_frame_stream_out;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] frame_w [16];

    logic [31:0] row_data, col_data, wrap_data;
    logic        row_valid, col_valid, wrap_valid;
    logic        row_sof, col_sof, wrap_sof;
    logic        row_eof, col_eof, wrap_eof;
    logic        row_busy, col_busy, wrap_busy;
    logic [15:0] row_frames, col_frames;
    logic [1:0]  wrap_frames;

    int total = 0;
    int bad = 0;

    // Model state: position in the frame being streamed (-1 = none), etc.
    int          m_pos = -1;
    int          m_gap = 0;
    int          m_frames = 0;
    bit          m_load = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_idle;
    logic [31:0] m_snap [16];

    logic [31:0] q_row [$];
    logic [31:0] q_col [$];
    bit          eof_seen = 1'b0;
    int          wrap_exp [5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    frame_stream_out #(.COL_MAJOR(1'b0), .GAP_CYCLES(GAP), .CNT_W(16)) dut_row (
        .clk(clk), .rst_n(rst_n),
        .frame_0_in(frame_w[0]), .frame_1_in(frame_w[1]), .frame_2_in(frame_w[2]), .frame_3_in(frame_w[3]),
        .frame_4_in(frame_w[4]), .frame_5_in(frame_w[5]), .frame_6_in(frame_w[6]), .frame_7_in(frame_w[7]),
        .frame_8_in(frame_w[8]), .frame_9_in(frame_w[9]), .frame_10_in(frame_w[10]), .frame_11_in(frame_w[11]),
        .frame_12_in(frame_w[12]), .frame_13_in(frame_w[13]), .frame_14_in(frame_w[14]), .frame_15_in(frame_w[15]),
        .start(start), .out_data(row_data), .out_valid(row_valid), .out_ready(out_ready),
        .out_sof(row_sof), .out_eof(row_eof), .busy(row_busy), .frames_sent(row_frames)
    );

    frame_stream_out #(.COL_MAJOR(1'b1), .GAP_CYCLES(GAP), .CNT_W(16)) dut_col (
        .clk(clk), .rst_n(rst_n),
        .frame_0_in(frame_w[0]), .frame_1_in(frame_w[1]), .frame_2_in(frame_w[2]), .frame_3_in(frame_w[3]),
        .frame_4_in(frame_w[4]), .frame_5_in(frame_w[5]), .frame_6_in(frame_w[6]), .frame_7_in(frame_w[7]),
        .frame_8_in(frame_w[8]), .frame_9_in(frame_w[9]), .frame_10_in(frame_w[10]), .frame_11_in(frame_w[11]),
        .frame_12_in(frame_w[12]), .frame_13_in(frame_w[13]), .frame_14_in(frame_w[14]), .frame_15_in(frame_w[15]),
        .start(start), .out_data(col_data), .out_valid(col_valid), .out_ready(out_ready),
        .out_sof(col_sof), .out_eof(col_eof), .busy(col_busy), .frames_sent(col_frames)
    );

    frame_stream_out #(.COL_MAJOR(1'b0), .GAP_CYCLES(GAP), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .frame_0_in(frame_w[0]), .frame_1_in(frame_w[1]), .frame_2_in(frame_w[2]), .frame_3_in(frame_w[3]),
        .frame_4_in(frame_w[4]), .frame_5_in(frame_w[5]), .frame_6_in(frame_w[6]), .frame_7_in(frame_w[7]),
        .frame_8_in(frame_w[8]), .frame_9_in(frame_w[9]), .frame_10_in(frame_w[10]), .frame_11_in(frame_w[11]),
        .frame_12_in(frame_w[12]), .frame_13_in(frame_w[13]), .frame_14_in(frame_w[14]), .frame_15_in(frame_w[15]),
        .start(start), .out_data(wrap_data), .out_valid(wrap_valid), .out_ready(out_ready),
        .out_sof(wrap_sof), .out_eof(wrap_eof), .busy(wrap_busy), .frames_sent(wrap_frames)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue position over a snapshot taken one cycle after the
    // request is accepted; after the last word it sits out GAP cycles before accepting again.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = -1; m_gap = 0; m_frames = 0; m_load = 1'b0; m_pend = 1'b0;
        end else begin
            m_idle = !m_load && (m_pos < 0) && (m_gap == 0);
            if (m_idle) begin
                if (start || m_pend) m_load = 1'b1;
                m_pend = m_pend && start;
            end else begin
                m_pend = m_pend || start;
                if (m_load) begin
                    m_load = 1'b0;
                    m_pos  = 0;
                    m_snap = frame_w;
                end else if (m_pos >= 0) begin
                    if (out_ready) begin
                        if (m_pos == 15) begin
                            m_frames++;
                            m_pos = -1;
                            m_gap = GAP;
                        end else begin
                            m_pos++;
                        end
                    end
                end else begin
                    m_gap--;
                end
            end
        end
    end

    // Single compare process: all three instances against the model, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("row_valid",  row_valid,  m_pos >= 0);
            check("col_valid",  col_valid,  m_pos >= 0);
            check("wrap_valid", wrap_valid, m_pos >= 0);
            check("row_busy",   row_busy,   m_load || m_pos >= 0 || m_gap > 0);
            check("col_busy",   col_busy,   m_load || m_pos >= 0 || m_gap > 0);
            check("wrap_busy",  wrap_busy,  m_load || m_pos >= 0 || m_gap > 0);
            check("row_frames",  row_frames,  m_frames % 65536);
            check("col_frames",  col_frames,  m_frames % 65536);
            check("wrap_frames", wrap_frames, m_frames % 4);
            if (m_pos >= 0) begin
                check("row_data",  row_data,  m_snap[m_pos]);
                check("wrap_data", wrap_data, m_snap[m_pos]);
                check("col_data",  col_data,  m_snap[(m_pos % 4) * 4 + m_pos / 4]);
                check("row_sof", row_sof, m_pos == 0);
                check("col_sof", col_sof, m_pos == 0);
                check("row_eof", row_eof, m_pos == 15);
                check("col_eof", col_eof, m_pos == 15);
            end
        end
    end

    // Sink: record every accepted word.
    always @(negedge clk) begin
        if (rst_n && row_valid && out_ready) begin
            q_row.push_back(row_data);
            q_col.push_back(col_data);
        end
        if (rst_n && row_valid && row_eof) eof_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_frame(input logic [31:0] base);
        for (int k = 0; k < 16; k++) frame_w[k] = base + 32'(k);
    endtask

    task automatic clear_sink();
        q_row.delete();
        q_col.delete();
        eof_seen = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            step();
            n++;
            quiet = row_busy ? 0 : quiet + 1;
        end
        total++;
        if (quiet < 3) begin
            bad++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", row_busy, budget);
        end
    endtask

    task automatic wait_word(input logic [31:0] value, input int budget);
        int n = 0;
        while (!(row_valid && row_data == value) && n < budget) begin
            step();
            n++;
        end
        check("wait_word", row_data, value);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (row_frames != 16'(target) && n < budget) begin
            step();
            n++;
        end
        check("wait_frames", row_frames, target);
    endtask

    task automatic check_frame(input string name, input int first, input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            check({name, "_row"}, q_row[first + i], base + 32'(i));
            check({name, "_col"}, q_col[first + i], base + 32'((i % 4) * 4 + i / 4));
        end
    endtask

    initial begin
        set_frame(32'hA000_0000);

        // Reset values
        step();
        step();
        check("rst_row_data",  row_data, 0);
        check("rst_row_valid", row_valid, 0);
        check("rst_row_sof",   row_sof, 0);
        check("rst_row_eof",   row_eof, 0);
        check("rst_row_busy",  row_busy, 0);
        check("rst_row_frames", row_frames, 0);
        check("rst_col_valid", col_valid, 0);
        check("rst_wrap_frames", wrap_frames, 0);
        rst_n = 1'b1;
        step();

        // Basic frame, latency and order
        clear_sink();
        out_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check("lat_load_valid", row_valid, 0);
        check("lat_load_busy", row_busy, 1);
        step();
        @(negedge clk);
        check("lat_first_valid", row_valid, 1);
        check("lat_first_data", row_data, 32'hA000_0000);
        check("lat_first_sof", row_sof, 1);
        wait_idle(100);
        check("basic_count", q_row.size(), 16);
        check_frame("basic", 0, 32'hA000_0000);
        check("basic_col_1", q_col[1], 32'hA000_0004);
        check("basic_col_4", q_col[4], 32'hA000_0001);
        check("basic_col_15", q_col[15], 32'hA000_000F);
        check("basic_frames", row_frames, 1);
        check("basic_eof_seen", eof_seen, 1);

        // Backpressure: stall at word 5, then random ready
        apply_reset();
        clear_sink();
        out_ready = 1'b1;
        pulse_start();
        wait_word(32'hA000_0005, 40);
        out_ready = 1'b0;
        repeat (3) begin
            step();
            check("stall_data", row_data, 32'hA000_0005);
            check("stall_valid", row_valid, 1);
            check("stall_col_data", col_data, 32'hA000_0005);
        end
        repeat (30) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b1;
        wait_idle(100);
        check("bp_count", q_row.size(), 16);
        check_frame("bp", 0, 32'hA000_0000);

        // Snapshot isolation and one queued start
        apply_reset();
        clear_sink();
        set_frame(32'hA000_0000);
        pulse_start();
        wait_word(32'hA000_0002, 20);
        set_frame(32'hB000_0000);
        pulse_start();
        step();
        pulse_start();
        wait_frames(2, 200);
        wait_idle(100);
        check("queue_count", q_row.size(), 32);
        check_frame("queue_a", 0, 32'hA000_0000);
        check_frame("queue_b", 16, 32'hB000_0000);
        check("queue_frames", row_frames, 2);

        // Reset mid-frame at word 7
        apply_reset();
        clear_sink();
        set_frame(32'hA000_0000);
        pulse_start();
        wait_word(32'hA000_0007, 30);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_data", row_data, 0);
        check("mid_rst_valid", row_valid, 0);
        check("mid_rst_sof", row_sof, 0);
        check("mid_rst_busy", row_busy, 0);
        check("mid_rst_col_valid", col_valid, 0);
        check("mid_rst_frames", row_frames, 0);
        check("mid_rst_words", q_row.size(), 7);
        check("mid_rst_no_eof", eof_seen, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        clear_sink();
        pulse_start();
        wait_idle(100);
        check("post_rst_count", q_row.size(), 16);
        check_frame("post_rst", 0, 32'hA000_0000);
        check("post_rst_frames", row_frames, 1);

        // Counter wrap on the 2-bit instance
        apply_reset();
        for (int f = 0; f < 5; f++) begin
            pulse_start();
            wait_idle(100);
            check("wrap_seq", wrap_frames, wrap_exp[f]);
        end

        // Random traffic: random data churn, ready and start pulses
        apply_reset();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 16; k++) frame_w[k] = $urandom;
            pulse_start();
            repeat (40) begin
                out_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0) frame_w[$urandom_range(0, 15)] = $urandom;
                step();
            end
            start = 1'b0;
            out_ready = 1'b1;
            wait_idle(200);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
